// File: rtl/riscv_hazard_pkg.sv
// Shared types and helpers for the decode-side hazard unit and its
// pending-write scoreboard.
package riscv_hazard_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam int NREGS = 32;

    // One-hot select of an architectural register
    function automatic logic [NREGS-1:0] onehot_reg(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Number of set bits in a scoreboard mask (x0 never set, so fits 6 bits)
    function automatic logic [5:0] popcount_mask(input logic [NREGS-1:0] m);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + 6'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pending_scoreboard.sv
// Per-register pending-write scoreboard for long-latency results.
// Holds the mask, its popcount, and a sticky error flag for writebacks
// that arrive for x0 or for a register with no outstanding write.
module pending_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_set_en,
    input  logic [4:0]  i_set_idx,
    input  logic [31:0] i_clr,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    output logic [31:0] o_mask,
    output logic [5:0]  o_cnt,
    output logic        o_err
);
    import riscv_hazard_pkg::*;

    logic [NREGS-1:0] r_mask;
    logic [5:0]       r_cnt;
    logic             r_err;
    logic [NREGS-1:0] w_mask_nxt;
    logic             w_bad_wb;

    // Next mask: retire writebacks first, then a new issue; set wins on same index
    always_comb begin
        w_mask_nxt = r_mask & ~i_clr;
        if (i_set_en) begin
            w_mask_nxt = w_mask_nxt | onehot_reg(i_set_idx);
        end
    end

    assign w_bad_wb = i_wb_valid && ((i_wb_rd == 5'd0) || !r_mask[i_wb_rd]);

    // Scoreboard state: mask, count tracking the mask, sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_cnt  <= popcount_mask(w_mask_nxt);
            if (w_bad_wb) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_mask = r_mask;
    assign o_cnt  = r_cnt;
    assign o_err  = r_err;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-side stall/flush generator: load-use interlock plus a pending
// scoreboard for long-latency writes (load miss, mul/div).
// Optional consecutive-stall watchdog enabled by defining SCB_TIMEOUT_EN;
// without it Timeout is tied low.
module scoreboard_hazard_unit #(
    parameter int NREGS          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             LongLatD,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             WbValidL,
    input  logic [4:0]       WbRdL,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [NREGS-1:0] PendingMask,
    output logic [5:0]       OutstandingCnt,
    output logic             ScbErr,
    output logic             Timeout
);
    import riscv_hazard_pkg::*;

    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_pend_eff;
    logic             w_lw_stall;
    logic             w_scb_stall;
    logic             w_hazard;
    logic             w_stall;
    logic             w_flush_e;
    logic             w_issue;

    // Writeback clear vector; x0 is never tracked
    always_comb begin
        w_clr = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_clr[i] = WbValidL && (WbRdL == reg_idx_t'(i));
        end
    end

    // A same-cycle writeback unblocks the reader (regfile writes before read)
    assign w_pend_eff = PendingMask & ~w_clr;

    assign w_lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_scb_stall = ((Rs1D != 5'd0) && w_pend_eff[Rs1D]) ||
                         ((Rs2D != 5'd0) && w_pend_eff[Rs2D]) ||
                         (RegWriteD && (RdD != 5'd0) && w_pend_eff[RdD]);

    assign w_hazard  = w_lw_stall || w_scb_stall;
    assign w_stall   = w_hazard && !PCSrcE;
    assign w_flush_e = w_hazard || PCSrcE;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushD = PCSrcE;
    assign FlushE = w_flush_e;

    // Only an instruction that actually leaves decode claims its destination
    assign w_issue = RegWriteD && LongLatD && (RdD != 5'd0) && !w_stall && !w_flush_e;

    pending_scoreboard u_scb (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_issue),
        .i_set_idx  (RdD),
        .i_clr      (w_clr),
        .i_wb_valid (WbValidL),
        .i_wb_rd    (WbRdL),
        .o_mask     (PendingMask),
        .o_cnt      (OutstandingCnt),
        .o_err      (ScbErr)
    );

`ifdef SCB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    // Watchdog: count consecutive decode stalls, saturate, latch Timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (w_stall) begin
            if (r_stall_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (r_stall_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign Timeout = r_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;
    localparam int NR  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD, RdE, WbRdL;
    logic        RegWriteD, LongLatD, LoadE, PCSrcE, WbValidL;
    logic        StallF, StallD, FlushD, FlushE, ScbErr, Timeout;
    logic [NR-1:0] PendingMask;
    logic [5:0]  OutstandingCnt;

    scoreboard_hazard_unit #(.NREGS(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .LongLatD(LongLatD), .RdE(RdE), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .WbValidL(WbValidL), .WbRdL(WbRdL),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PendingMask(PendingMask), .OutstandingCnt(OutstandingCnt),
        .ScbErr(ScbErr), .Timeout(Timeout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: which registers have a write outstanding
    bit m_pend [NR];
    bit m_err;
    bit m_to;
    int m_run;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit blocked(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(WbValidL && (WbRdL == r));
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0; RdE = 0; WbRdL = 0;
        RegWriteD = 0; LongLatD = 0; LoadE = 0; PCSrcE = 0; WbValidL = 0;
        reset = 0;
    endtask

    // Compare all outputs to the model, advance the model, then clock
    task automatic tick();
        bit lw, scb, stall, fle, issue;
        logic [NR-1:0] mv;
        int cnt;
        #2;
        lw    = LoadE && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
        scb   = blocked(Rs1D) || blocked(Rs2D) || (RegWriteD && blocked(RdD));
        stall = (lw || scb) && !PCSrcE;
        fle   = lw || scb || PCSrcE;
        mv = '0; cnt = 0;
        for (int i = 0; i < NR; i++) begin
            mv[i] = m_pend[i];
            cnt += int'(m_pend[i]);
        end
        chk("StallF", StallF, stall);
        chk("StallD", StallD, stall);
        chk("FlushD", FlushD, PCSrcE);
        chk("FlushE", FlushE, fle);
        chk("PendingMask", PendingMask, mv);
        chk("OutstandingCnt", OutstandingCnt, cnt);
        chk("ScbErr", ScbErr, m_err);
        chk("Timeout", Timeout, m_to);
        issue = RegWriteD && LongLatD && (RdD != 0) && !fle;
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_err = 0; m_to = 0; m_run = 0;
        end else begin
            if (WbValidL) begin
                if (WbRdL == 0 || !m_pend[WbRdL]) m_err = 1;
                else m_pend[WbRdL] = 0;
            end
            if (issue) m_pend[RdD] = 1;
`ifdef SCB_TIMEOUT_EN
            if (stall) begin
                if (m_run < TMO) m_run++;
                if (m_run >= TMO) m_to = 1;
            end else begin
                m_run = 0;
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit exp_to;
`ifdef SCB_TIMEOUT_EN
        exp_to = 1;
`else
        exp_to = 0;
`endif
        foreach (m_pend[i]) m_pend[i] = 0;
        m_err = 0; m_to = 0; m_run = 0;
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_mask", PendingMask, 0);
        chk("rst_cnt", OutstandingCnt, 0);
        chk("rst_err", ScbErr, 0);
        chk("rst_timeout", Timeout, 0);

        // Load-use
        LoadE = 1; RdE = 5; Rs1D = 5;
        #1 chk("lu_stall", StallD, 1);
        chk("lu_flushe", FlushE, 1);
        chk("lu_flushd", FlushD, 0);
        tick();
        RdE = 0; Rs1D = 0;
        #1 chk("lu_x0_nostall", StallD, 0);
        tick();
        idle();

        // Long-latency issue to x7, RAW stall until writeback
        RegWriteD = 1; LongLatD = 1; RdD = 7;
        tick();
        idle();
        chk("iss7_bit", PendingMask[7], 1);
        chk("iss7_cnt", OutstandingCnt, 1);
        Rs2D = 7;
        tick();
        tick();
        WbValidL = 1; WbRdL = 7;
        #1 chk("wb7_unblock", StallD, 0);
        tick();
        idle();
        chk("wb7_clear", PendingMask[7], 0);

        // Same-cycle set and clear on x9, then WAW stall
        RegWriteD = 1; LongLatD = 1; RdD = 9;
        tick();
        WbValidL = 1; WbRdL = 9;
        tick();
        idle();
        chk("sc9_bit", PendingMask[9], 1);
        chk("sc9_cnt", OutstandingCnt, 1);
        RegWriteD = 1; RdD = 9;
        #1 chk("waw_stall", StallD, 1);
        tick();
        idle();

        // Redirect overrides stall and blocks issue
        Rs1D = 9; PCSrcE = 1; RegWriteD = 1; LongLatD = 1; RdD = 10;
        #1 chk("br_flushd", FlushD, 1);
        chk("br_flushe", FlushE, 1);
        chk("br_stalld", StallD, 0);
        tick();
        idle();
        chk("br_noissue", PendingMask[10], 0);

        // Hold a stall for the watchdog
        Rs1D = 9;
        repeat (5) tick();
        chk("timeout_hold", Timeout, exp_to);
        idle();

        // Clean writeback, then spurious writeback to x3
        WbValidL = 1; WbRdL = 9;
        tick();
        idle();
        WbValidL = 1; WbRdL = 3;
        tick();
        idle();
        chk("err_set", ScbErr, 1);
        repeat (3) tick();
        chk("err_sticky", ScbErr, 1);
        reset = 1;
        tick();
        idle();
        chk("err_reset", ScbErr, 0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int q[$];
            reset     = ((cyc % 400) == 399);
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            RdD       = 5'($urandom_range(0, 7));
            RdE       = 5'($urandom_range(0, 7));
            RegWriteD = ($urandom_range(0, 9) < 7);
            LongLatD  = ($urandom_range(0, 9) < 5);
            LoadE     = ($urandom_range(0, 9) < 2);
            PCSrcE    = ($urandom_range(0, 9) < 1);
            WbValidL  = ($urandom_range(0, 9) < 4);
            for (int i = 0; i < NR; i++) if (m_pend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) < 9)
                WbRdL = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                WbRdL = 5'($urandom_range(0, 7));
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
